// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch slice.
//   fetch_state_t : fetch sequencer states
//   ADDR_W_DEF    : default PC / memory word-address width
//   INSTR_W_DEF   : default instruction width
//   PC_RESET      : PC value the surrounding PC register comes out of reset with
package fetch_unit_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [31:0] PC_RESET = 32'd107;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DISCARD
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: IF/ID output register plus a one-entry hold register.
//   clk, reset           : clock, synchronous active-high reset
//   load                 : a fetched instruction arrives this cycle
//   load_instr, load_pc  : the arriving instruction and its address
//   drain                : move the hold entry into the output register
//   stall                : decode cannot take the current output
//   flush                : drop the output and hold entries (redirect)
//   if_valid/instr/pc    : output register towards decode
//   free                 : output register can accept a load this cycle
module fetch_buffer #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic               drain,
    input  logic               stall,
    input  logic               flush,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               free
);

    logic               hold_valid;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_pc;

    // The current output is consumed this cycle unless decode is stalling on it.
    assign free = !if_valid || !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            hold_valid <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (flush) begin
            if_valid   <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            if (load && free) begin
                if_valid <= 1'b1;
                if_instr <= load_instr;
                if_pc    <= load_pc;
            end else if (drain && hold_valid) begin
                if_valid   <= 1'b1;
                if_instr   <= hold_instr;
                if_pc      <= hold_pc;
                hold_valid <= 1'b0;
            end else if (!stall) begin
                if_valid <= 1'b0;
            end

            // Output still occupied by a stalled instruction: park the new one.
            if (load && !free) begin
                hold_valid <= 1'b1;
                hold_instr <= load_instr;
                hold_pc    <= load_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer between PC register, instruction
// memory port and decode. One outstanding request at most; redirects flush
// the IF/ID register and drain a stale in-flight response via DISCARD.
//   clk, reset                   : clock, synchronous active-high reset
//   pc / pc_next / pc_write      : PC register value in, next value + write pulse out
//   imem_req/addr/gnt            : read request handshake (addr follows pc)
//   imem_rvalid/rdata            : read response, no backpressure
//   redirect / redirect_pc       : taken branch/jump from a later stage
//   stall                        : decode cannot accept a new instruction
//   if_valid/if_instr/if_pc      : IF/ID output register
//   perf_fetched/perf_stall_cycles : counters, present only with FETCH_PERF_EN
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               pc_write,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall_cycles
`endif
);

    fetch_state_t state_q, state_d;
    logic         redir;
    logic         load, drain, flush;
    logic         buf_free;

    // IDLE only exists for the cycle after reset; redirects are ignored there.
    assign redir     = redirect && (state_q != IDLE);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        pc_write = 1'b0;
        pc_next  = '0;
        load     = 1'b0;
        drain    = 1'b0;
        flush    = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req = 1'b1;
                // A granted request that gets redirected still owes a response.
                if (redir)         state_d = imem_gnt ? DISCARD : REQ;
                else if (imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (redir) begin
                    state_d = imem_rvalid ? REQ : DISCARD;
                end else if (imem_rvalid) begin
                    load     = 1'b1;
                    pc_write = 1'b1;
                    pc_next  = pc + ADDR_W'(1);
                    state_d  = buf_free ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (redir) begin
                    state_d = REQ;
                end else if (!stall) begin
                    drain   = 1'b1;
                    state_d = REQ;
                end
            end
            DISCARD: if (imem_rvalid) state_d = REQ;
            default: state_d = IDLE;
        endcase

        if (redir) begin
            pc_write = 1'b1;
            pc_next  = redirect_pc;
            flush    = 1'b1;
        end
    end

    fetch_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .drain      (drain),
        .stall      (stall),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .free       (buf_free)
    );

`ifdef FETCH_PERF_EN
    // load/drain are already suppressed on redirect, so flushed fetches never count.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if ((load && buf_free) || drain) perf_fetched <= perf_fetched + 32'd1;
            if (if_valid && stall)           perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit. The bench owns a
// PC register (loaded from pc_next on pc_write) and a per-cycle vector table of
// memory/decode inputs with hand-computed expected outputs.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_next     (pc_next),
        .pc_write    (pc_write),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // PC register that the fetch unit reads and writes back.
    always @(posedge clk) begin
        if (reset)         pc <= PC_RESET;
        else if (pc_write) pc <= pc_next;
    end

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_pcw;
        logic [31:0] e_pcn;
        logic        e_ifv;
        logic [31:0] e_ifi;
        logic [31:0] e_ifp;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vec [NVEC];

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    initial begin
        // stall gnt rv rdata redir rpc | req addr pcw pcn ifv ifi ifp
        vec[0]  = '{0,0,0,32'h0,0,32'h0,         0,32'd107,0,32'd0,0,32'h0,32'd0};
        vec[1]  = '{0,1,0,32'h0,0,32'h0,         1,32'd107,0,32'd0,0,32'h0,32'd0};
        vec[2]  = '{0,0,1,32'hAABB0001,0,32'h0,  0,32'd107,1,32'd108,0,32'h0,32'd0};
        vec[3]  = '{1,1,0,32'h0,0,32'h0,         1,32'd108,0,32'd0,1,32'hAABB0001,32'd107};
        vec[4]  = '{1,0,1,32'hAABB0002,0,32'h0,  0,32'd108,1,32'd109,1,32'hAABB0001,32'd107};
        vec[5]  = '{1,0,0,32'h0,0,32'h0,         0,32'd109,0,32'd0,1,32'hAABB0001,32'd107};
        vec[6]  = '{1,0,0,32'h0,0,32'h0,         0,32'd109,0,32'd0,1,32'hAABB0001,32'd107};
        vec[7]  = '{0,0,0,32'h0,0,32'h0,         0,32'd109,0,32'd0,1,32'hAABB0001,32'd107};
        vec[8]  = '{0,0,0,32'h0,0,32'h0,         1,32'd109,0,32'd0,1,32'hAABB0002,32'd108};
        vec[9]  = '{0,1,0,32'h0,0,32'h0,         1,32'd109,0,32'd0,0,32'hAABB0002,32'd108};
        vec[10] = '{0,0,0,32'h0,1,32'd200,       0,32'd109,1,32'd200,0,32'hAABB0002,32'd108};
        vec[11] = '{0,0,0,32'h0,0,32'h0,         0,32'd200,0,32'd0,0,32'hAABB0002,32'd108};
        vec[12] = '{0,0,1,32'hDEAD,0,32'h0,      0,32'd200,0,32'd0,0,32'hAABB0002,32'd108};
        vec[13] = '{0,1,0,32'h0,0,32'h0,         1,32'd200,0,32'd0,0,32'hAABB0002,32'd108};
        vec[14] = '{0,0,1,32'hBEEF0200,1,32'd300,0,32'd200,1,32'd300,0,32'hAABB0002,32'd108};
        vec[15] = '{0,1,0,32'h0,1,32'hFFFFFFFF,  1,32'd300,1,32'hFFFFFFFF,0,32'hAABB0002,32'd108};
        vec[16] = '{0,0,1,32'h1234,0,32'h0,      0,32'hFFFFFFFF,0,32'd0,0,32'hAABB0002,32'd108};
        vec[17] = '{0,1,0,32'h0,0,32'h0,         1,32'hFFFFFFFF,0,32'd0,0,32'hAABB0002,32'd108};
        vec[18] = '{0,0,1,32'hCAFE0003,0,32'h0,  0,32'hFFFFFFFF,1,32'd0,0,32'hAABB0002,32'd108};
        vec[19] = '{0,0,0,32'h0,0,32'h0,         1,32'd0,0,32'd0,1,32'hCAFE0003,32'hFFFFFFFF};
        vec[20] = '{0,0,0,32'h0,0,32'h0,         1,32'd0,0,32'd0,0,32'hCAFE0003,32'hFFFFFFFF};

        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;

        // Reset state, sampled while reset is still held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_if_valid", -1, {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", -1, if_instr, 32'd0);
        chk("rst_if_pc",    -1, if_pc, 32'd0);
        chk("rst_imem_req", -1, {31'd0, imem_req}, 32'd0);
        chk("rst_pc_write", -1, {31'd0, pc_write}, 32'd0);
        chk("rst_pc_next",  -1, pc_next, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Row i is the i-th cycle after reset release (row 0 is IDLE).
        for (int i = 0; i < NVEC; i++) begin
            stall       = vec[i].stall;
            imem_gnt    = vec[i].gnt;
            imem_rvalid = vec[i].rvalid;
            imem_rdata  = vec[i].rdata;
            redirect    = vec[i].redir;
            redirect_pc = vec[i].rpc;
            #1;
            chk("imem_req",  i, {31'd0, imem_req}, {31'd0, vec[i].e_req});
            chk("imem_addr", i, imem_addr, vec[i].e_addr);
            chk("pc_write",  i, {31'd0, pc_write}, {31'd0, vec[i].e_pcw});
            chk("pc_next",   i, pc_next, vec[i].e_pcn);
            chk("if_valid",  i, {31'd0, if_valid}, {31'd0, vec[i].e_ifv});
            chk("if_instr",  i, if_instr, vec[i].e_ifi);
            chk("if_pc",     i, if_pc, vec[i].e_ifp);
            @(negedge clk);
        end

        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        #1;
`ifdef FETCH_PERF_EN
        // Fetched: 0xAABB0001, 0xAABB0002 (via hold), 0xCAFE0003; stalled rows 3..6.
        chk("perf_fetched",      -1, perf_fetched, 32'd3);
        chk("perf_stall_cycles", -1, perf_stall_cycles, 32'd4);
`endif

        // Reset mid-run returns everything to zero.
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst2_if_valid", -1, {31'd0, if_valid}, 32'd0);
        chk("rst2_if_instr", -1, if_instr, 32'd0);
        chk("rst2_imem_req", -1, {31'd0, imem_req}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst2_perf_fetched",      -1, perf_fetched, 32'd0);
        chk("rst2_perf_stall_cycles", -1, perf_stall_cycles, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
